// File: rtl/param_updown_counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
// Mode and ONESHOT state encodings live here so the interface, top and bench agree.
package param_updown_counter_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP    = 2'b00,
    CNT_SAT     = 2'b01,
    CNT_ONESHOT = 2'b10,
    CNT_RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } cnt_state_e;

  function automatic logic [31:0] clamp_max(input logic [31:0] value, input logic [31:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Drive/monitor bundle for the counter: control inputs from the master, status back from the slave.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  import param_updown_counter_pkg::*;

  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             up_down;
  cnt_mode_e        mode;
  logic             start;
  logic             clr_flags;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             unf;
  logic             busy;

  modport master (
    output load, din, en, up_down, mode, start, clr_flags,
    input  count, tc, ovf, unf, busy
  );

  modport slave (
    input  load, din, en, up_down, mode, start, clr_flags,
    output count, tc, ovf, unf, busy
  );

  modport mon (
    input load, din, en, up_down, mode, start, clr_flags,
    input count, tc, ovf, unf, busy
  );

endinterface

// File: rtl/param_updown_counter_cnt_step_unit.sv
// Combinational step: computes the count after one step and whether that step hits a boundary.
// Boundary behaviour depends on mode: WRAP/reserved wraps around, SAT/ONESHOT holds.
module cnt_step_unit
  import param_updown_counter_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] next_count,
  output logic             at_boundary
);

  logic at_max;
  logic at_zero;
  logic wraps;

  assign at_max  = (count == MAX_VAL);
  assign at_zero = (count == '0);
  assign wraps   = (mode == CNT_WRAP) || (mode == CNT_RSVD);

  always_comb begin
    next_count  = count;
    at_boundary = 1'b0;
    if (up_down) begin
      if (at_max) begin
        at_boundary = 1'b1;
        next_count  = wraps ? '0 : count;
      end else begin
        next_count = count + 1'b1;
      end
    end else begin
      if (at_zero) begin
        at_boundary = 1'b1;
        next_count  = wraps ? MAX_VAL : count;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Loadable up/down counter with programmable modulus, WRAP/SAT/ONESHOT modes,
// terminal-count pulse and sticky overflow/underflow flags.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned MAX_VAL = (2**WIDTH)-1
) (
  input logic                    clock,
  input logic                    resetn,
  param_updown_counter_if.slave  bus
);

  // state   | meaning
  // ST_IDLE | ONESHOT waiting for start (also the resting state in other modes)
  // ST_RUN  | ONESHOT counting on en
  // ST_DONE | ONESHOT reached a boundary, waiting for start

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             busy_q, busy_d;
  cnt_state_e       state_q, state_d;

  logic [WIDTH-1:0] next_count;
  logic             at_boundary;
  logic [WIDTH-1:0] din_clamped;
  logic             oneshot;
  logic             step_ok;

  cnt_step_unit #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_C)
  ) u_step (
    .count       (count_q),
    .up_down     (bus.up_down),
    .mode        (bus.mode),
    .next_count  (next_count),
    .at_boundary (at_boundary)
  );

  assign din_clamped = WIDTH'(clamp_max(32'(bus.din), 32'(MAX_VAL)));
  assign oneshot     = (bus.mode == CNT_ONESHOT);
  assign step_ok     = oneshot ? (bus.en && (state_q == ST_RUN)) : bus.en;

  // Clear is applied first so a same-cycle set event overrides it.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~bus.clr_flags;
    unf_d   = unf_q & ~bus.clr_flags;
    state_d = state_q;
    if (bus.load) begin
      count_d = din_clamped;
      state_d = ST_IDLE;
    end else begin
      if (step_ok) begin
        count_d = next_count;
        if (at_boundary) begin
          tc_d = 1'b1;
          if (bus.up_down) ovf_d = 1'b1;
          else             unf_d = 1'b1;
          if (oneshot)     state_d = ST_DONE;
        end
      end
      if (!oneshot) begin
        state_d = ST_IDLE;
      end else if (bus.start && (state_q != ST_RUN)) begin
        state_d = ST_RUN;
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      busy_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      busy_q  <= busy_d;
      state_q <= state_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: a WIDTH=4/MAX_VAL=9 instance for mode behaviour and a WIDTH=8 full-range instance.
module tb_param_updown_counter;
  import param_updown_counter_pkg::*;

  logic clock;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  param_updown_counter_if #(.WIDTH(4)) bus4 ();
  param_updown_counter_if #(.WIDTH(8)) bus8 ();

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9)) dut4 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus4)
  );

  param_updown_counter #(.WIDTH(8), .MAX_VAL(255)) dut8 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv4(input logic ld, input logic [3:0] d, input logic e, input logic up,
                      input cnt_mode_e m, input logic st, input logic clr);
    bus4.load = ld; bus4.din = d; bus4.en = e; bus4.up_down = up;
    bus4.mode = m; bus4.start = st; bus4.clr_flags = clr;
    tick();
  endtask

  task automatic drv8(input logic ld, input logic [7:0] d, input logic e, input logic up);
    bus4.load = 1'b0; bus4.en = 1'b0; bus4.start = 1'b0; bus4.clr_flags = 1'b0;
    bus8.load = ld; bus8.din = d; bus8.en = e; bus8.up_down = up;
    bus8.mode = CNT_WRAP; bus8.start = 1'b0; bus8.clr_flags = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    bus4.load = 0; bus4.din = 0; bus4.en = 0; bus4.up_down = 0;
    bus4.mode = CNT_WRAP; bus4.start = 0; bus4.clr_flags = 0;
    bus8.load = 0; bus8.din = 0; bus8.en = 0; bus8.up_down = 0;
    bus8.mode = CNT_WRAP; bus8.start = 0; bus8.clr_flags = 0;
    repeat (2) tick();
    chk("rst_count", 32'(bus4.count), 0);
    chk("rst_tc",    32'(bus4.tc),    0);
    chk("rst_ovf",   32'(bus4.ovf),   0);
    chk("rst_unf",   32'(bus4.unf),   0);
    chk("rst_busy",  32'(bus4.busy),  0);
    chk("rst_cnt8",  32'(bus8.count), 0);
    @(negedge clock);
    resetn = 1'b1;

    // WRAP up through 9
    drv4(1, 8, 0, 1, CNT_WRAP, 0, 0);
    chk("wrap_load", 32'(bus4.count), 8);
    drv4(0, 0, 1, 1, CNT_WRAP, 0, 0);
    chk("wrap_c9",  32'(bus4.count), 9);
    chk("wrap_tc0", 32'(bus4.tc), 0);
    drv4(0, 0, 1, 1, CNT_WRAP, 0, 0);
    chk("wrap_c0",  32'(bus4.count), 0);
    chk("wrap_tc1", 32'(bus4.tc), 1);
    chk("wrap_ovf", 32'(bus4.ovf), 1);
    chk("wrap_unf", 32'(bus4.unf), 0);

    // SAT down through 0
    drv4(1, 1, 0, 0, CNT_SAT, 0, 0);
    chk("sat_load", 32'(bus4.count), 1);
    drv4(0, 0, 1, 0, CNT_SAT, 0, 0);
    chk("sat_c0a",  32'(bus4.count), 0);
    chk("sat_tc_a", 32'(bus4.tc), 0);
    chk("sat_unf_a", 32'(bus4.unf), 0);
    drv4(0, 0, 1, 0, CNT_SAT, 0, 0);
    chk("sat_c0b",  32'(bus4.count), 0);
    chk("sat_tc_b", 32'(bus4.tc), 1);
    chk("sat_unf_b", 32'(bus4.unf), 1);
    drv4(0, 0, 1, 0, CNT_SAT, 0, 0);
    chk("sat_c0c",  32'(bus4.count), 0);
    chk("sat_tc_c", 32'(bus4.tc), 1);
    drv4(0, 0, 0, 0, CNT_SAT, 0, 1);
    chk("clr_unf", 32'(bus4.unf), 0);
    chk("clr_ovf", 32'(bus4.ovf), 0);
    chk("clr_tc",  32'(bus4.tc), 0);

    // Load clamp and load priority over count
    drv4(1, 15, 0, 1, CNT_WRAP, 0, 0);
    chk("clamp", 32'(bus4.count), 9);
    drv4(1, 3, 1, 1, CNT_WRAP, 0, 0);
    chk("load_prio", 32'(bus4.count), 3);

    // ONESHOT
    drv4(1, 7, 0, 1, CNT_ONESHOT, 0, 0);
    chk("os_load", 32'(bus4.count), 7);
    chk("os_idle_busy", 32'(bus4.busy), 0);
    drv4(0, 0, 1, 1, CNT_ONESHOT, 0, 0);
    chk("os_idle_hold", 32'(bus4.count), 7);
    drv4(0, 0, 0, 1, CNT_ONESHOT, 1, 0);
    chk("os_start_busy", 32'(bus4.busy), 1);
    chk("os_start_cnt",  32'(bus4.count), 7);
    drv4(0, 0, 1, 1, CNT_ONESHOT, 0, 0);
    chk("os_c8", 32'(bus4.count), 8);
    drv4(0, 0, 1, 1, CNT_ONESHOT, 1, 0);
    chk("os_c9", 32'(bus4.count), 9);
    chk("os_c9_tc", 32'(bus4.tc), 0);
    drv4(0, 0, 1, 1, CNT_ONESHOT, 0, 0);
    chk("os_hold9", 32'(bus4.count), 9);
    chk("os_tc", 32'(bus4.tc), 1);
    chk("os_done_busy", 32'(bus4.busy), 0);
    chk("os_ovf", 32'(bus4.ovf), 1);
    drv4(0, 0, 1, 1, CNT_ONESHOT, 0, 0);
    chk("os_done_cnt", 32'(bus4.count), 9);
    chk("os_done_tc", 32'(bus4.tc), 0);
    drv4(0, 0, 0, 0, CNT_ONESHOT, 1, 0);
    chk("os_restart_busy", 32'(bus4.busy), 1);
    drv4(0, 0, 1, 0, CNT_ONESHOT, 0, 0);
    chk("os_down8", 32'(bus4.count), 8);
    drv4(0, 0, 0, 0, CNT_WRAP, 0, 0);
    chk("mode_exit_busy", 32'(bus4.busy), 0);

    // Set wins over clear
    drv4(0, 0, 0, 1, CNT_WRAP, 0, 1);
    chk("pre_clr_ovf", 32'(bus4.ovf), 0);
    drv4(1, 9, 0, 1, CNT_WRAP, 0, 0);
    drv4(0, 0, 1, 1, CNT_WRAP, 0, 1);
    chk("setwin_cnt", 32'(bus4.count), 0);
    chk("setwin_ovf", 32'(bus4.ovf), 1);
    chk("setwin_tc",  32'(bus4.tc), 1);

    // 8-bit full-range wrap
    drv8(1, 8'd255, 0, 1);
    chk("w8_load", 32'(bus8.count), 255);
    drv8(0, 8'd0, 1, 1);
    chk("w8_c0",  32'(bus8.count), 0);
    chk("w8_tc",  32'(bus8.tc), 1);
    chk("w8_ovf", 32'(bus8.ovf), 1);
    drv8(0, 8'd0, 1, 0);
    chk("w8_c255", 32'(bus8.count), 255);
    chk("w8_unf",  32'(bus8.unf), 1);
    drv8(0, 8'd0, 1, 0);
    chk("w8_c254", 32'(bus8.count), 254);
    chk("w8_tc0",  32'(bus8.tc), 0);

    // Asynchronous reset mid-count
    drv4(1, 5, 0, 1, CNT_WRAP, 0, 0);
    drv4(0, 0, 1, 1, CNT_WRAP, 0, 0);
    chk("ar_c6", 32'(bus4.count), 6);
    #2 resetn = 1'b0;
    #1;
    chk("ar_cnt", 32'(bus4.count), 0);
    chk("ar_ovf", 32'(bus4.ovf), 0);
    chk("ar_cnt8", 32'(bus8.count), 0);
    repeat (3) tick();
    chk("ar_hold", 32'(bus4.count), 0);
    chk("ar_hold_unf8", 32'(bus8.unf), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
